spi_wb_bridge: RTL and testbench



---
 rtl/spi_wb_bridge.sv | 139 +++++++++++++
 tb/tb_spi_wb_bridge.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_wb_bridge.sv
// Parses received SPI bytes into single 32-bit Wishbone classic accesses and streams read data back out.
// Bus cycle starts the cycle after the last command byte; read response bytes follow one per tx_ready cycle.
// Stalls indefinitely on tx_ready=0; bytes arriving while a bus cycle or response is in flight are dropped and flag overrun.
module spi_wb_bridge #(
    parameter int unsigned pWbTimeout   = 255,
    parameter int unsigned pIdleTimeout = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_stb,
    output logic [7:0]  tx_data,
    output logic        tx_stb,
    input  logic        tx_ready,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [6:0]  wb_adr,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack,
    output logic        timeout,
    output logic        overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WDATA = 2'd1,
        BUS   = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Counters compare against limit-1 so the transition lands exactly limit cycles after entry.
    localparam logic [15:0] WB_LIM   = 16'(pWbTimeout - 1);
    localparam logic [15:0] IDLE_LIM = 16'(pIdleTimeout - 1);

    state_t      state;
    logic [15:0] cnt;
    logic [1:0]  byte_cnt;
    logic [31:0] resp_word;

    assign wb_stb = wb_cyc;
    assign wb_sel = 4'hF;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            byte_cnt  <= '0;
            resp_word <= '0;
            wb_cyc    <= 1'b0;
            wb_we     <= 1'b0;
            wb_adr    <= '0;
            wb_dat_o  <= '0;
            tx_data   <= '0;
            tx_stb    <= 1'b0;
            timeout   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            tx_stb  <= 1'b0;
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_stb) begin
                        wb_adr   <= rx_data[6:0];
                        wb_we    <= rx_data[7];
                        cnt      <= '0;
                        byte_cnt <= '0;
                        if (rx_data[7]) begin
                            state <= WDATA;
                        end else begin
                            state  <= BUS;
                            wb_cyc <= 1'b1;
                        end
                    end
                end
                WDATA: begin
                    // A byte arriving on the idle-limit cycle still belongs to this command.
                    if (rx_stb) begin
                        wb_dat_o <= {wb_dat_o[23:0], rx_data};
                        cnt      <= '0;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state  <= BUS;
                            wb_cyc <= 1'b1;
                        end
                    end else if (cnt == IDLE_LIM) begin
                        state    <= IDLE;
                        wb_dat_o <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                BUS: begin
                    if (rx_stb) begin
                        overrun <= 1'b1;
                    end
                    if (wb_ack) begin
                        wb_cyc   <= 1'b0;
                        cnt      <= '0;
                        byte_cnt <= '0;
                        if (wb_we) begin
                            state <= IDLE;
                        end else begin
                            resp_word <= wb_dat_i;
                            state     <= RESP;
                        end
                    end else if (cnt == WB_LIM) begin
                        wb_cyc    <= 1'b0;
                        timeout   <= 1'b1;
                        cnt       <= '0;
                        byte_cnt  <= '0;
                        resp_word <= '1;
                        state     <= wb_we ? IDLE : RESP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RESP: begin
                    if (rx_stb) begin
                        overrun <= 1'b1;
                    end
                    if (tx_ready) begin
                        tx_stb    <= 1'b1;
                        tx_data   <= resp_word[31:24];
                        resp_word <= {resp_word[23:0], 8'h00};
                        byte_cnt  <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_wb_bridge.sv
// Directed bench for spi_wb_bridge: write, read, bus timeout, idle discard, tx backpressure, async reset.
module tb_spi_wb_bridge;

    localparam int WB_TO   = 8;
    localparam int IDLE_TO = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_stb = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_stb;
    logic        tx_ready = 1'b0;
    logic        wb_cyc, wb_stb, wb_we;
    logic [6:0]  wb_adr;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack = 1'b0;
    logic        timeout, overrun;

    spi_wb_bridge #(.pWbTimeout(WB_TO), .pIdleTimeout(IDLE_TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data), .rx_stb(rx_stb),
        .tx_data(tx_data), .tx_stb(tx_stb), .tx_ready(tx_ready),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
        .wb_dat_o(wb_dat_o), .wb_sel(wb_sel), .wb_dat_i(wb_dat_i), .wb_ack(wb_ack),
        .timeout(timeout), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int npass = 0;
    int ntotal = 0;

    // Bus/tx monitor, sampled on the falling edge.
    int          cyc_no = 0;
    int          cur_len = 0;
    int          last_len = 0;
    int          ncyc = 0;
    int          n_to = 0;
    int          stb_bad = 0;
    logic        to_at_fall = 1'b0;
    logic        last_we = 1'b0;
    logic [6:0]  last_adr = '0;
    logic [31:0] last_dat = '0;
    logic [3:0]  last_sel = '0;
    logic [7:0]  tx_q[$];
    int          tx_t[$];

    always @(negedge clk) begin
        cyc_no++;
        if (wb_stb !== wb_cyc) stb_bad++;
        if (timeout) n_to++;
        if (tx_stb) begin
            tx_q.push_back(tx_data);
            tx_t.push_back(cyc_no);
        end
        if (wb_cyc) begin
            if (cur_len == 0) begin
                last_we  = wb_we;
                last_adr = wb_adr;
                last_dat = wb_dat_o;
                last_sel = wb_sel;
            end
            cur_len++;
        end else if (cur_len != 0) begin
            last_len   = cur_len;
            to_at_fall = timeout;
            cur_len    = 0;
            ncyc++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Called at a falling edge; rx_stb is high for exactly one rising edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_stb  = 1'b1;
        @(negedge clk);
        rx_stb  = 1'b0;
    endtask

    task automatic ack_now(input logic [31:0] d);
        wb_dat_i = d;
        wb_ack   = 1'b1;
        @(negedge clk);
        wb_ack   = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        tx_q.delete();
        tx_t.delete();
        n_to = 0;
    endtask

    function automatic logic [31:0] tx_word();
        if (tx_q.size() < 4) return 32'hxxxxxxxx;
        return {tx_q[0], tx_q[1], tx_q[2], tx_q[3]};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int ncyc0;

        // Reset values.
        wait_cycles(3);
        check("rst_ctrl", {26'd0, wb_cyc, wb_stb, wb_we, tx_stb, timeout, overrun}, 32'd0);
        check("rst_adr_tx", {17'd0, wb_adr, tx_data}, 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        check("rst_sel", {28'd0, wb_sel}, 32'hF);
        rst_n = 1'b1;
        wait_cycles(2);

        // Write 0x12345678 to address 5, ack two cycles after cyc rises.
        send_byte(8'h85);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        send_byte(8'h78);
        check("wr_cyc_rise", {31'd0, wb_cyc}, 32'd1);
        wait_cycles(2);
        ack_now(32'h0);
        wait_cycles(3);
        check("wr_ncyc", ncyc, 1);
        check("wr_len", last_len, 3);
        check("wr_attr", {20'd0, last_we, last_adr, last_sel}, {20'd0, 1'b1, 7'h05, 4'hF});
        check("wr_dat", last_dat, 32'h12345678);
        check("wr_no_tx", tx_q.size(), 0);

        // Read address 3, immediate ack.
        tx_ready = 1'b1;
        send_byte(8'h03);
        check("rd_cyc_rise", {31'd0, wb_cyc}, 32'd1);
        ack_now(32'hCAFEF00D);
        wait_cycles(8);
        check("rd_len", last_len, 1);
        check("rd_attr", {24'd0, last_we, last_adr}, {24'd0, 1'b0, 7'h03});
        check("rd_ntx", tx_q.size(), 4);
        check("rd_bytes", tx_word(), 32'hCAFEF00D);
        check("rd_b2b", (tx_t.size() == 4) ? tx_t[3] - tx_t[0] : -1, 3);
        clear_mon();

        // Read with no ack: bus timeout.
        send_byte(8'h07);
        wait_cycles(20);
        check("to_len", last_len, WB_TO);
        check("to_pulse_at_fall", {31'd0, to_at_fall}, 32'd1);
        check("to_pulse_count", n_to, 1);
        check("to_bytes", tx_word(), 32'hFFFFFFFF);
        check("to_ntx", tx_q.size(), 4);
        clear_mon();

        // Partial write abandoned after the idle limit; next byte is a fresh read command.
        ncyc0 = ncyc;
        send_byte(8'h81);
        send_byte(8'hAA);
        wait_cycles(IDLE_TO);
        send_byte(8'h02);
        check("idle_cyc_rise", {31'd0, wb_cyc}, 32'd1);
        ack_now(32'h11223344);
        wait_cycles(8);
        check("idle_one_cycle", ncyc - ncyc0, 1);
        check("idle_attr", {24'd0, last_we, last_adr}, {24'd0, 1'b0, 7'h02});
        check("idle_bytes", tx_word(), 32'h11223344);
        clear_mon();

        // Bytes arriving exactly at the idle limit still count.
        send_byte(8'h84);
        send_byte(8'hDE);
        wait_cycles(IDLE_TO - 1);
        send_byte(8'hAD);
        wait_cycles(IDLE_TO - 1);
        send_byte(8'hBE);
        wait_cycles(IDLE_TO - 1);
        send_byte(8'hEF);
        check("edge_cyc_rise", {31'd0, wb_cyc}, 32'd1);
        ack_now(32'h0);
        wait_cycles(3);
        check("edge_attr", {24'd0, last_we, last_adr}, {24'd0, 1'b1, 7'h04});
        check("edge_dat", last_dat, 32'hDEADBEEF);

        // Read with tx backpressure and a stray byte during the response.
        tx_ready = 1'b0;
        send_byte(8'h09);
        ack_now(32'hA1B2C3D4);
        wait_cycles(5);
        check("bp_hold", tx_q.size(), 0);
        check("bp_no_ovr", {31'd0, overrun}, 32'd0);
        ncyc0 = ncyc;
        for (int i = 0; i < 10; i++) begin
            tx_ready = (i % 2 == 0);
            rx_data  = 8'h55;
            rx_stb   = (i == 2);
            @(negedge clk);
        end
        tx_ready = 1'b0;
        rx_stb   = 1'b0;
        wait_cycles(5);
        check("bp_ntx", tx_q.size(), 4);
        check("bp_bytes", tx_word(), 32'hA1B2C3D4);
        check("bp_overrun", {31'd0, overrun}, 32'd1);
        check("bp_no_extra_cyc", ncyc - ncyc0, 0);
        clear_mon();

        // Asynchronous reset in the middle of a bus cycle.
        send_byte(8'h0A);
        wait_cycles(2);
        check("arst_pre", {31'd0, wb_cyc}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_cyc", {30'd0, wb_cyc, wb_stb}, 32'd0);
        check("arst_ovr", {31'd0, overrun}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cycles(2);
        send_byte(8'h86);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        check("post_cyc_rise", {31'd0, wb_cyc}, 32'd1);
        ack_now(32'h0);
        wait_cycles(3);
        check("post_len", last_len, 1);
        check("post_attr", {24'd0, last_we, last_adr}, {24'd0, 1'b1, 7'h06});
        check("post_dat", last_dat, 32'h01020304);
        check("post_no_tx", tx_q.size(), 0);
        check("stb_follows_cyc", stb_bad, 0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
